// File: rtl/uart_pkg.sv
// Shared UART constants and the TX FIFO hold-register state type.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int CLK_FRE         = 50;      // MHz
  localparam int BAUD_RATE       = 115200;

  typedef enum logic {
    H_EMPTY  = 1'b0,
    H_LOADED = 1'b1
  } hold_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM for the UART TX FIFO: synchronous write and asynchronous read.
module uart_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter: RAM plus one output hold register,
// with fill level, almost-full and a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] L_CAP   = (ADDR_WIDTH+1)'(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] L_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH+1)'(1);

  if (AFULL_LEVEL > DEPTH + 1 || AFULL_LEVEL < 0) begin : g_bad_afull
    $error("uart_tx_fifo: AFULL_LEVEL must lie in 0..DEPTH+1");
  end

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_overflow;
  hold_state_t           r_state;
  hold_state_t           w_state_nxt;

  logic                  w_full;
  logic                  w_ram_empty;
  logic                  w_wr_en;
  logic                  w_pop;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Full is judged on the whole capacity (RAM + hold) from registered level only.
  assign w_full      = (r_level == L_CAP);
  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr_en     = in_valid && !w_full && !flush;

  assign in_ready    = !w_full;
  assign out_valid   = w_pop;
  assign out_data    = r_hold;
  assign level       = r_level;
  assign almost_full = (r_level >= L_AFULL);
  assign overflow    = r_overflow;

  uart_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= H_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // The byte is only offered while the transmitter is ready; a pop with the
  // RAM non-empty reloads the hold register in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = H_EMPTY;
    end else begin
      case (r_state)
        H_EMPTY: begin
          if (!w_ram_empty) begin
            w_load      = 1'b1;
            w_state_nxt = H_LOADED;
          end
        end
        H_LOADED: begin
          if (out_ready) begin
            w_pop = 1'b1;
            if (w_ram_empty) w_state_nxt = H_EMPTY;
            else             w_load      = 1'b1;
          end
        end
        default: w_state_nxt = H_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_hold   <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + L_ONE;
        if (w_load) begin
          r_hold   <= w_ram_rdata;
          r_rd_ptr <= r_rd_ptr + L_ONE;
        end
        case ({w_wr_en, w_pop})
          2'b10:   r_level <= r_level + L_ONE;
          2'b01:   r_level <= r_level - L_ONE;
          default: r_level <= r_level;
        endcase
      end
      if (in_valid && w_full && !flush) r_overflow <= 1'b1;
      else if (clr_overflow)            r_overflow <= 1'b0;
    end
  end

endmodule
